// File: rtl/biquad8_pkg.sv
// Shared types and register map for the biquad8 coefficient loader.
package biquad8_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StGap,
        StCommit,
        StCgap
    } state_e;

    localparam logic [6:0] ADR_UPDATE  = 7'h00;
    localparam logic [6:0] ADR_FIR     = 7'h04;
    localparam logic [6:0] ADR_IIR     = 7'h08;
    localparam logic [6:0] ADR_INC     = 7'h0C;
    localparam logic [6:0] ADR_POLEFIR = 7'h10;

    typedef struct packed {
        logic [6:0]  adr;
        logic [17:0] dat;
    } entry_t;

endpackage

// File: rtl/biquad8_loader_fifo.sv
// First-word-fall-through entry FIFO: o_rdata always shows the head entry.
module biquad8_loader_fifo
    import biquad8_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  entry_t        i_wdata,
    input  logic          i_pop,
    input  logic          i_flush,
    output entry_t        o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Buffers coefficient writes and drains them over a WISHBONE master port,
// optionally finishing with a write to the update register.
module biquad8_coeff_loader
    import biquad8_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          ent_valid_i,
    output logic          ent_ready_o,
    input  logic [6:0]    ent_adr_i,
    input  logic [17:0]   ent_dat_i,
    input  logic          start_i,
    input  logic          commit_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [CW-1:0] count_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [6:0]    wb_adr_o,
    output logic [31:0]   wb_dat_o,
    output logic [3:0]    wb_sel_o,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e        r_state;
    logic          r_commit;
    logic [TW-1:0] r_tmo;
    logic          r_cyc;
    logic          r_we;
    logic [6:0]    r_adr;
    logic [31:0]   r_dat;
    logic [3:0]    r_sel;
    logic          r_done;
    logic          r_err;

    entry_t        w_in;
    entry_t        w_head;
    entry_t        w_load;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_active;
    logic          w_fail;
    logic          w_have;
    logic          w_want_commit;

    assign w_in          = {ent_adr_i, ent_dat_i};
    assign ent_ready_o   = !w_full && (r_state == StIdle);
    assign w_push        = ent_valid_i && ent_ready_o;
    // A push in the same cycle as start_i lands in an empty FIFO; write it directly.
    assign w_load        = w_empty ? w_in : w_head;
    assign w_have        = !w_empty || w_push;
    assign w_want_commit = (r_state == StIdle) ? commit_i : r_commit;
    assign w_active      = (r_state == StWrite) || (r_state == StCommit);
    assign w_fail        = w_active && (wb_err_i || wb_rty_i ||
                                        (!wb_ack_i && (r_tmo == TW'(TIMEOUT))));
    assign w_pop         = (r_state == StWrite) && wb_ack_i && !wb_err_i && !wb_rty_i;

    biquad8_loader_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_n_i),
        .i_push  (w_push),
        .i_wdata (w_in),
        .i_pop   (w_pop),
        .i_flush (w_fail),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count_o)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_state  <= StIdle;
            r_commit <= 1'b0;
            r_tmo    <= '0;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_sel    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                StIdle, StGap: begin
                    if (r_state == StGap || start_i) begin
                        if (r_state == StIdle) begin
                            r_commit <= commit_i;
                        end
                        if (w_have) begin
                            r_state <= StWrite;
                            r_tmo   <= '0;
                            r_cyc   <= 1'b1;
                            r_we    <= 1'b1;
                            r_adr   <= w_load.adr;
                            r_dat   <= {14'b0, w_load.dat};
                            r_sel   <= 4'hF;
                        end else if (w_want_commit) begin
                            r_state <= StCommit;
                            r_tmo   <= '0;
                            r_cyc   <= 1'b1;
                            r_we    <= 1'b1;
                            r_adr   <= ADR_UPDATE;
                            r_dat   <= 32'h1;
                            r_sel   <= 4'h1;
                        end else begin
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StWrite, StCommit: begin
                    // Bus error/retry first, then ack, which beats an expiring timeout.
                    if (w_fail) begin
                        r_state <= StIdle;
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (wb_ack_i) begin
                        r_state <= (r_state == StWrite) ? StGap : StCgap;
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                StCgap: begin
                    r_state <= StIdle;
                    r_done  <= 1'b1;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy_o   = (r_state != StIdle);
    assign done_o   = r_done;
    assign err_o    = r_err;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign wb_we_o  = r_we;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = r_sel;

endmodule
